// File: rtl/core_mem_arb_pkg.sv
// Shared constants and types for the core memory port arbiter.
// Requester ids, access encodings, field widths, issue-stage bundle.
package core_mem_arb_pkg;

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  localparam logic [1:0] ORDER_LINE = 2'h3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int TID_W   = 14;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 64;
  localparam int FLAGS_W = 12;
  localparam int WDATA_W = 32;
  localparam int PDT_W   = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [1:0]         order;
    logic               rw;
    logic [TID_W-1:0]   tid;
    logic [1:0]         mmumod;
    logic [PDT_W-1:0]   pdt;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/core_mem_arb_tag_fifo.sv
// In-order requester-tag FIFO for outstanding reads (1-bit entries).
// Ports: clk, rst, push/push_id, pop, head_id, count, full, empty.
module core_mem_arb_tag_fifo #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [DEPTH_W:0] count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0]   mem;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Depth is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == (DEPTH_W+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/core_mem_port_arbiter.sv
// Shares one memory port between I-cache refill and data load/store.
// Ports: iINST_* / iDATA_* requesters, oMEM_* / iMEM_* memory, oPROTO_ERR.
module core_mem_port_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int   OUTSTANDING   = 4,
  parameter int   OUTSTANDING_W = 2,
  parameter logic RR_INIT       = 1'b0
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               iINST_REQ,
  output logic               oINST_LOCK,
  input  logic [TID_W-1:0]   iINST_TID,
  input  logic [1:0]         iINST_MMUMOD,
  input  logic [PDT_W-1:0]   iINST_PDT,
  input  logic [ADDR_W-1:0]  iINST_ADDR,
  output logic               oINST_VALID,
  input  logic               iINST_BUSY,
  output logic [LINE_W-1:0]  oINST_DATA,
  output logic [FLAGS_W-1:0] oINST_MMU_FLAGS,
  input  logic               iDATA_REQ,
  output logic               oDATA_LOCK,
  input  logic [1:0]         iDATA_ORDER,
  input  logic               iDATA_RW,
  input  logic [TID_W-1:0]   iDATA_TID,
  input  logic [1:0]         iDATA_MMUMOD,
  input  logic [PDT_W-1:0]   iDATA_PDT,
  input  logic [ADDR_W-1:0]  iDATA_ADDR,
  input  logic [WDATA_W-1:0] iDATA_DATA,
  output logic               oDATA_VALID,
  output logic [LINE_W-1:0]  oDATA_DATA,
  output logic               oMEM_REQ,
  input  logic               iMEM_LOCK,
  output logic [1:0]         oMEM_ORDER,
  output logic               oMEM_RW,
  output logic [TID_W-1:0]   oMEM_TID,
  output logic [1:0]         oMEM_MMUMOD,
  output logic [PDT_W-1:0]   oMEM_PDT,
  output logic [ADDR_W-1:0]  oMEM_ADDR,
  output logic [WDATA_W-1:0] oMEM_DATA,
  input  logic               iMEM_VALID,
  output logic               oMEM_BUSY,
  input  logic [LINE_W-1:0]  iMEM_DATA,
  input  logic [FLAGS_W-1:0] iMEM_MMU_FLAGS,
  output logic               oPROTO_ERR
);

  localparam logic [OUTSTANDING_W:0] CNT_MAX =
    (OUTSTANDING_W+1)'(OUTSTANDING);

  issue_state_t state;
  mem_req_t     stage;
  mem_req_t     next_req;
  logic         rr_ptr;

  logic                 can_load;
  logic                 read_credit;
  logic                 inst_elig;
  logic                 data_elig;
  logic                 inst_gnt;
  logic                 data_gnt;
  logic                 any_gnt;
  logic                 push;
  logic                 push_id;
  logic                 pop;
  logic                 head_id;
  logic [OUTSTANDING_W:0] fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_inst;
  logic                 head_data;

  // No grant while reset is held: the stage could not capture it.
  assign can_load = !iRESET &&
    ((state == ST_IDLE) || !iMEM_LOCK);

  // Count includes the read still in the stage; a same-cycle
  // pop does not free a slot.
  assign read_credit = !fifo_full && (fifo_count < CNT_MAX);

  assign inst_elig = iINST_REQ && can_load && read_credit;
  assign data_elig = iDATA_REQ && can_load &&
    ((iDATA_RW == RW_WRITE) || read_credit);

  assign inst_gnt = inst_elig &&
    (!data_elig || rr_ptr == REQ_ID_INST);
  assign data_gnt = data_elig &&
    (!inst_elig || rr_ptr == REQ_ID_DATA);
  assign any_gnt  = inst_gnt || data_gnt;

  assign oINST_LOCK = !inst_gnt;
  assign oDATA_LOCK = !data_gnt;

  always_comb begin
    next_req = '0;
    unique case (1'b1)
      inst_gnt: begin
        next_req.order  = ORDER_LINE;
        next_req.rw     = RW_READ;
        next_req.tid    = iINST_TID;
        next_req.mmumod = iINST_MMUMOD;
        next_req.pdt    = iINST_PDT;
        next_req.addr   = iINST_ADDR;
        next_req.data   = '0;
      end
      default: begin
        next_req.order  = iDATA_ORDER;
        next_req.rw     = iDATA_RW;
        next_req.tid    = iDATA_TID;
        next_req.mmumod = iDATA_MMUMOD;
        next_req.pdt    = iDATA_PDT;
        next_req.addr   = iDATA_ADDR;
        next_req.data   = iDATA_DATA;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state    <= ST_IDLE;
      stage    <= '0;
      oMEM_REQ <= 1'b0;
      rr_ptr   <= RR_INIT;
    end else begin
      // Pointer only moves on a contested grant.
      if (inst_elig && data_elig)
        rr_ptr <= ~rr_ptr;
      unique case (state)
        ST_IDLE: begin
          if (any_gnt) begin
            state    <= ST_ISSUE;
            stage    <= next_req;
            oMEM_REQ <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (any_gnt) begin
            stage <= next_req;
          end else if (!iMEM_LOCK) begin
            state    <= ST_IDLE;
            oMEM_REQ <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          oMEM_REQ <= 1'b0;
        end
      endcase
    end
  end

  assign oMEM_ORDER  = stage.order;
  assign oMEM_RW     = stage.rw;
  assign oMEM_TID    = stage.tid;
  assign oMEM_MMUMOD = stage.mmumod;
  assign oMEM_PDT    = stage.pdt;
  assign oMEM_ADDR   = stage.addr;
  assign oMEM_DATA   = stage.data;

  assign push    = inst_gnt || (data_gnt && iDATA_RW == RW_READ);
  assign push_id = data_gnt ? REQ_ID_DATA : REQ_ID_INST;

  core_mem_arb_tag_fifo #(
    .DEPTH   (OUTSTANDING),
    .DEPTH_W (OUTSTANDING_W)
  ) u_tag_fifo (
    .clk     (iCLOCK),
    .rst     (iRESET),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_inst = !fifo_empty && (head_id == REQ_ID_INST);
  assign head_data = !fifo_empty && (head_id == REQ_ID_DATA);

  assign oMEM_BUSY   = head_inst && iINST_BUSY;
  assign oINST_VALID = iMEM_VALID && head_inst && !iINST_BUSY;
  assign oDATA_VALID = iMEM_VALID && head_data;
  assign pop         = iMEM_VALID && !fifo_empty && !oMEM_BUSY;

  assign oINST_DATA      = iMEM_DATA;
  assign oINST_MMU_FLAGS = iMEM_MMU_FLAGS;
  assign oDATA_DATA      = iMEM_DATA;

  // A response with nothing outstanding is dropped and flagged.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET)
      oPROTO_ERR <= 1'b0;
    else if (iMEM_VALID && fifo_empty)
      oPROTO_ERR <= 1'b1;
  end

endmodule

// File: tb/tb_core_mem_port_arbiter.sv
// Randomised scoreboard bench for core_mem_port_arbiter.
// Stimulus pushes expected issues/responses; a negedge monitor checks.
module tb_core_mem_port_arbiter;
  import core_mem_arb_pkg::*;

  localparam int OUTS = 4;

  logic        iCLOCK = 1'b0;
  logic        iRESET;
  logic        iINST_REQ;
  logic        oINST_LOCK;
  logic [13:0] iINST_TID;
  logic [1:0]  iINST_MMUMOD;
  logic [31:0] iINST_PDT;
  logic [31:0] iINST_ADDR;
  logic        oINST_VALID;
  logic        iINST_BUSY;
  logic [63:0] oINST_DATA;
  logic [11:0] oINST_MMU_FLAGS;
  logic        iDATA_REQ;
  logic        oDATA_LOCK;
  logic [1:0]  iDATA_ORDER;
  logic        iDATA_RW;
  logic [13:0] iDATA_TID;
  logic [1:0]  iDATA_MMUMOD;
  logic [31:0] iDATA_PDT;
  logic [31:0] iDATA_ADDR;
  logic [31:0] iDATA_DATA;
  logic        oDATA_VALID;
  logic [63:0] oDATA_DATA;
  logic        oMEM_REQ;
  logic        iMEM_LOCK;
  logic [1:0]  oMEM_ORDER;
  logic        oMEM_RW;
  logic [13:0] oMEM_TID;
  logic [1:0]  oMEM_MMUMOD;
  logic [31:0] oMEM_PDT;
  logic [31:0] oMEM_ADDR;
  logic [31:0] oMEM_DATA;
  logic        iMEM_VALID;
  logic        oMEM_BUSY;
  logic [63:0] iMEM_DATA;
  logic [11:0] iMEM_MMU_FLAGS;
  logic        oPROTO_ERR;

  always #5 iCLOCK = ~iCLOCK;

  core_mem_port_arbiter #(
    .OUTSTANDING   (OUTS),
    .OUTSTANDING_W (2),
    .RR_INIT       (1'b0)
  ) dut (
    .iCLOCK          (iCLOCK),
    .iRESET          (iRESET),
    .iINST_REQ       (iINST_REQ),
    .oINST_LOCK      (oINST_LOCK),
    .iINST_TID       (iINST_TID),
    .iINST_MMUMOD    (iINST_MMUMOD),
    .iINST_PDT       (iINST_PDT),
    .iINST_ADDR      (iINST_ADDR),
    .oINST_VALID     (oINST_VALID),
    .iINST_BUSY      (iINST_BUSY),
    .oINST_DATA      (oINST_DATA),
    .oINST_MMU_FLAGS (oINST_MMU_FLAGS),
    .iDATA_REQ       (iDATA_REQ),
    .oDATA_LOCK      (oDATA_LOCK),
    .iDATA_ORDER     (iDATA_ORDER),
    .iDATA_RW        (iDATA_RW),
    .iDATA_TID       (iDATA_TID),
    .iDATA_MMUMOD    (iDATA_MMUMOD),
    .iDATA_PDT       (iDATA_PDT),
    .iDATA_ADDR      (iDATA_ADDR),
    .iDATA_DATA      (iDATA_DATA),
    .oDATA_VALID     (oDATA_VALID),
    .oDATA_DATA      (oDATA_DATA),
    .oMEM_REQ        (oMEM_REQ),
    .iMEM_LOCK       (iMEM_LOCK),
    .oMEM_ORDER      (oMEM_ORDER),
    .oMEM_RW         (oMEM_RW),
    .oMEM_TID        (oMEM_TID),
    .oMEM_MMUMOD     (oMEM_MMUMOD),
    .oMEM_PDT        (oMEM_PDT),
    .oMEM_ADDR       (oMEM_ADDR),
    .oMEM_DATA       (oMEM_DATA),
    .iMEM_VALID      (iMEM_VALID),
    .oMEM_BUSY       (oMEM_BUSY),
    .iMEM_DATA       (iMEM_DATA),
    .iMEM_MMU_FLAGS  (iMEM_MMU_FLAGS),
    .oPROTO_ERR      (oPROTO_ERR)
  );

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
  } rsp_t;

  req_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem_q[$];

  int total = 0;
  int bad   = 0;

  int p_inst, p_data, p_wr, p_lock, p_resp, p_busy;
  bit fix_en, inject, mon_en;
  logic [31:0] fix_addr;

  bit m_rr, exp_ig, exp_dg, exp_proto;
  bit stage_now, inst_hold, data_hold, resp_taken;
  int rsp_start;

  req_t mr;
  rsp_t mh;
  bit   hb;

  task automatic check(string nm, logic [127:0] act,
                       logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic bit pct(int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic logic [63:0] line_of(logic [31:0] a);
    if (a == 32'h100) return 64'hDEADBEEF_01234567;
    return {~a, a};
  endfunction

  function automatic logic [11:0] flags_of(logic [31:0] a);
    return a[15:4] ^ 12'hA5A;
  endfunction

  task automatic zero_inputs();
    iINST_REQ = 0; iINST_TID = 0; iINST_MMUMOD = 0;
    iINST_PDT = 0; iINST_ADDR = 0; iINST_BUSY = 0;
    iDATA_REQ = 0; iDATA_ORDER = 0; iDATA_RW = 0;
    iDATA_TID = 0; iDATA_MMUMOD = 0; iDATA_PDT = 0;
    iDATA_ADDR = 0; iDATA_DATA = 0;
    iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_DATA = 0;
    iMEM_MMU_FLAGS = 0;
  endtask

  task automatic clear_model();
    iss_q.delete(); rsp_q.delete(); mem_q.delete();
    m_rr = 1'b0; exp_ig = 0; exp_dg = 0; exp_proto = 0;
    stage_now = 0; rsp_start = 0;
    inst_hold = 0; data_hold = 0; resp_taken = 0;
  endtask

  task automatic check_reset(string nm);
    check({nm, "_req"}, oMEM_REQ, 0);
    check({nm, "_fields"},
      {oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD,
       oMEM_PDT, oMEM_ADDR, oMEM_DATA}, 0);
    check({nm, "_valids"}, {oINST_VALID, oDATA_VALID}, 0);
    check({nm, "_busy"}, oMEM_BUSY, 0);
    check({nm, "_proto"}, oPROTO_ERR, 0);
    check({nm, "_rdata"},
      {oINST_DATA, oDATA_DATA, oINST_MMU_FLAGS}, 0);
  endtask

  // One cycle of stimulus plus the expected grant for it.
  task automatic step();
    bit ie, de, cl, cr;
    @(posedge iCLOCK); #1;
    stage_now = iss_q.size() != 0;
    rsp_start = rsp_q.size();
    cr = rsp_start < OUTS;
    if (!inst_hold) begin
      iINST_REQ    = pct(p_inst);
      iINST_TID    = 14'($urandom);
      iINST_MMUMOD = 2'($urandom);
      iINST_PDT    = $urandom;
      iINST_ADDR   = fix_en ? fix_addr : ($urandom & ~32'h7);
    end
    if (!data_hold) begin
      iDATA_REQ    = pct(p_data);
      iDATA_RW     = !pct(p_wr);
      iDATA_ORDER  = 2'($urandom);
      iDATA_TID    = 14'($urandom);
      iDATA_MMUMOD = 2'($urandom);
      iDATA_PDT    = $urandom;
      iDATA_ADDR   = $urandom;
      iDATA_DATA   = $urandom;
    end
    iMEM_LOCK  = pct(p_lock);
    iINST_BUSY = pct(p_busy);
    if (!(iMEM_VALID && !resp_taken)) begin
      if (inject) begin
        iMEM_VALID = 1; iMEM_DATA = 64'h5555;
        iMEM_MMU_FLAGS = 12'h0;
      end else if (mem_q.size() != 0 && pct(p_resp)) begin
        iMEM_VALID     = 1;
        iMEM_DATA      = line_of(mem_q[0]);
        iMEM_MMU_FLAGS = flags_of(mem_q[0]);
      end else begin
        iMEM_VALID = 0;
      end
    end
    cl = !stage_now || !iMEM_LOCK;
    ie = iINST_REQ && cl && cr;
    de = iDATA_REQ && cl && (!iDATA_RW || cr);
    exp_ig = ie && (!de || !m_rr);
    exp_dg = de && (!ie || m_rr);
    if (ie && de) m_rr = !m_rr;
    if (exp_ig) begin
      iss_q.push_back({2'h3, 1'b1, iINST_TID, iINST_MMUMOD,
                       iINST_PDT, iINST_ADDR, 32'h0});
      rsp_q.push_back({1'b0, iINST_ADDR});
    end
    if (exp_dg) begin
      iss_q.push_back({iDATA_ORDER, iDATA_RW, iDATA_TID,
                       iDATA_MMUMOD, iDATA_PDT, iDATA_ADDR,
                       iDATA_DATA});
      if (iDATA_RW) rsp_q.push_back({1'b1, iDATA_ADDR});
    end
    inst_hold = iINST_REQ && !exp_ig;
    data_hold = iDATA_REQ && !exp_dg;
  endtask

  // Monitor: compares DUT against scoreboard queues each cycle.
  always @(negedge iCLOCK) begin
    if (mon_en) begin
      check("proto_err", oPROTO_ERR, exp_proto);
      check("inst_lock", oINST_LOCK, !exp_ig);
      check("data_lock", oDATA_LOCK, !exp_dg);
      check("mem_req", oMEM_REQ, stage_now);
      if (stage_now) begin
        mr = iss_q[0];
        check("mem_fields",
          {oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD,
           oMEM_PDT, oMEM_ADDR, oMEM_DATA}, mr);
        if (!iMEM_LOCK) begin
          if (mr.rw) mem_q.push_back(mr.addr);
          void'(iss_q.pop_front());
        end
      end
      resp_taken = 0;
      if (rsp_start == 0) begin
        check("busy_empty", oMEM_BUSY, 0);
        check("valid_empty", {oINST_VALID, oDATA_VALID}, 0);
        if (iMEM_VALID) begin
          exp_proto  = 1;
          resp_taken = 1;
        end
      end else begin
        mh = rsp_q[0];
        hb = !mh.id && iINST_BUSY;
        check("mem_busy", oMEM_BUSY, hb);
        check("inst_valid", oINST_VALID,
              iMEM_VALID && !mh.id && !iINST_BUSY);
        check("data_valid", oDATA_VALID, iMEM_VALID && mh.id);
        if (iMEM_VALID && !hb) begin
          if (!mh.id)
            check("inst_rdata", {oINST_MMU_FLAGS, oINST_DATA},
                  {flags_of(mh.addr), line_of(mh.addr)});
          else
            check("data_rdata", oDATA_DATA, line_of(mh.addr));
          void'(rsp_q.pop_front());
          if (mem_q.size() != 0) void'(mem_q.pop_front());
          else check("resp_unissued", 1'b1, 1'b0);
          resp_taken = 1;
        end
      end
    end
  end

  task automatic knobs(int pi, int pd, int pw, int pl,
                       int pr, int pb);
    p_inst = pi; p_data = pd; p_wr = pw;
    p_lock = pl; p_resp = pr; p_busy = pb;
  endtask

  task automatic drain();
    int n = 0;
    knobs(0, 0, 0, 0, 100, 30);
    while ((rsp_q.size() != 0 || iss_q.size() != 0 ||
            inst_hold || data_hold) && n < 300) begin
      step();
      n++;
    end
    step();
    step();
    check("drain_bound", n < 300, 1'b1);
  endtask

  task automatic reset_now(string nm);
    @(posedge iCLOCK); #2;
    mon_en = 0;
    iRESET = 1;
    zero_inputs();
    #1;
    check_reset(nm);
    @(negedge iCLOCK); #1;
    iRESET = 0;
    clear_model();
    mon_en = 1;
  endtask

  initial begin
    zero_inputs();
    clear_model();
    knobs(0, 0, 0, 0, 0, 0);
    fix_en = 0; inject = 0; mon_en = 0; fix_addr = 0;
    iRESET = 1;
    repeat (2) @(posedge iCLOCK);
    #1 check_reset("reset");
    @(negedge iCLOCK); #1;
    iRESET = 0;
    mon_en = 1;

    // Single instruction line read at 0x100.
    knobs(100, 0, 0, 0, 100, 0);
    fix_en = 1; fix_addr = 32'h100;
    step();
    fix_en = 0;
    knobs(0, 0, 0, 0, 100, 0);
    repeat (4) step();
    drain();

    // Both requesters reading every cycle.
    knobs(100, 100, 0, 0, 100, 0);
    repeat (12) step();
    drain();

    // Memory port locked with both requesters active.
    knobs(100, 100, 0, 100, 0, 0);
    repeat (3) step();
    knobs(100, 100, 0, 0, 100, 0);
    repeat (6) step();
    drain();

    // Fill read credit, then writes still go through.
    knobs(100, 0, 0, 0, 0, 0);
    repeat (8) step();
    knobs(100, 100, 100, 0, 0, 0);
    repeat (3) step();
    knobs(100, 0, 0, 0, 100, 0);
    repeat (4) step();
    drain();

    // Instruction sink stalls.
    knobs(100, 0, 0, 0, 100, 100);
    repeat (6) step();
    knobs(0, 0, 0, 0, 100, 0);
    repeat (4) step();
    drain();

    // Response with nothing outstanding.
    inject = 1;
    step();
    inject = 0;
    repeat (4) step();

    // Reset in the middle of traffic.
    knobs(70, 70, 30, 30, 60, 30);
    repeat (25) step();
    reset_now("midrst");
    repeat (2) step();

    // Randomised traffic.
    for (int b = 0; b < 20; b++) begin
      knobs($urandom_range(100), $urandom_range(100),
            $urandom_range(60), $urandom_range(60),
            $urandom_range(100), $urandom_range(70));
      repeat (80) step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
